// File: rtl/crc_7_pkg.sv
// Shared definitions for the SD CRC7 peripherals: register map, status bit
// positions, the CRC7 polynomial, frame length and FSM state encoding.
package crc_7_pkg;

   // SD command/response frame length in bits
   localparam int FRAME_BITS = 48;

   // CRC7 polynomial x^7 + x^3 + 1 (the x^7 term is implicit)
   localparam logic [6:0] CRC7_POLY = 7'h09;

   // Register map
   localparam logic [3:0] ADDR_FRAME_HI  = 4'h0;  // frame[47:32]
   localparam logic [3:0] ADDR_FRAME_MID = 4'h2;  // frame[31:16]
   localparam logic [3:0] ADDR_FRAME_LO  = 4'h4;  // frame[15:0]
   localparam logic [3:0] ADDR_CTRL      = 4'h6;  // bit0 = start (write only)
   localparam logic [3:0] ADDR_STATUS    = 4'h8;  // read only
   localparam logic [3:0] ADDR_CRC       = 4'hA;  // computed CRC in bits[6:0]

   // Status bit positions
   localparam int STAT_DONE   = 0;
   localparam int STAT_CRC_OK = 1;
   localparam int STAT_END_OK = 2;
   localparam int STAT_BUSY   = 3;

   // Checker FSM
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SHIFT   = 2'd1,
      ST_COMPARE = 2'd2,
      ST_DONE    = 2'd3
   } crc_state_e;

endpackage : crc_7_pkg

// File: rtl/crc_7_serial_core.sv
// Bit-serial CRC7 engine (x^7 + x^3 + 1), one message bit per enabled cycle,
// MSB first. A clear takes priority over a bit update in the same cycle.
module crc_7_serial_core
   import crc_7_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr_i,
   input  logic       en_i,
   input  logic       bit_i,
   output logic [6:0] crc_o
);

   logic [6:0] crc_q;
   logic [6:0] crc_d;
   logic       fb;

   // Next CRC value for the incoming bit
   always_comb begin
      fb    = crc_q[6] ^ bit_i;
      crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   end

   // CRC register: clear, shift in one bit, or hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_q <= 7'h00;
      end else if (clr_i) begin
         crc_q <= 7'h00;
      end else if (en_i) begin
         crc_q <= crc_d;
      end
   end

   assign crc_o = crc_q;

endmodule : crc_7_serial_core

// File: rtl/peripheral_crc_7_check.sv
// Bus-mapped SD CRC7 checker. Software loads a 48-bit frame as three 16-bit
// words, writes start, and after 41 clocks reads done/crc_ok/end_ok.
// Frame bits 47..8 are fed through the CRC engine, then the result is
// compared with frame[7:1] and the end bit frame[0] is checked.
// Optional build macro: CRC7_CHECK_CLR_ON_READ_EN -- a status read in DONE
// clears done/crc_ok/end_ok on the same edge it returns them.
module peripheral_crc_7_check
   import crc_7_pkg::*;
#(
   parameter int FRAME_BITS = crc_7_pkg::FRAME_BITS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] d_in,
   input  logic        cs,
   input  logic [3:0]  addr,
   input  logic        rd,
   input  logic        wr,
   output logic [15:0] d_out
);

   crc_state_e            state_q;
   logic [5:0]            bit_cnt_q;
   logic                  done_q;
   logic                  crc_ok_q;
   logic                  end_ok_q;
   logic [15:0]           frame_hi_q;
   logic [15:0]           frame_mid_q;
   logic [15:0]           frame_lo_q;
   logic [15:0]           d_out_q;
   logic [15:0]           d_out_d;
   logic [15:0]           status;
   logic [FRAME_BITS-1:0] frame;
   logic [6:0]            crc;
   logic                  busy;
   logic                  wr_en;
   logic                  rd_en;
   logic                  start_wr;
   logic                  crc_clr;
   logic                  crc_en;

   assign frame    = {frame_hi_q, frame_mid_q, frame_lo_q};
   assign busy     = (state_q == ST_SHIFT) || (state_q == ST_COMPARE);
   assign wr_en    = cs && wr;
   assign rd_en    = cs && rd;
   assign start_wr = wr_en && (addr == ADDR_CTRL) && d_in[0];
   assign crc_clr  = start_wr && !busy;
   assign crc_en   = (state_q == ST_SHIFT);

   crc_7_serial_core u_core (
      .clk   (clk),
      .rst_n (rst),
      .clr_i (crc_clr),
      .en_i  (crc_en),
      .bit_i (frame[bit_cnt_q]),
      .crc_o (crc)
   );

   // Frame words: writable only while no check is in progress
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_hi_q  <= 16'h0000;
         frame_mid_q <= 16'h0000;
         frame_lo_q  <= 16'h0000;
      end else if (wr_en && !busy) begin
         if (addr == ADDR_FRAME_HI)  frame_hi_q  <= d_in;
         if (addr == ADDR_FRAME_MID) frame_mid_q <= d_in;
         if (addr == ADDR_FRAME_LO)  frame_lo_q  <= d_in;
      end
   end

   // Checker FSM with registered result flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= 6'd0;
         done_q    <= 1'b0;
         crc_ok_q  <= 1'b0;
         end_ok_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_wr) begin
                  done_q    <= 1'b0;
                  crc_ok_q  <= 1'b0;
                  end_ok_q  <= 1'b0;
                  bit_cnt_q <= 6'(FRAME_BITS - 1);
                  state_q   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // Bits 47 down to 8 go through the engine; 7..0 are CRC and end bit
               if (bit_cnt_q == 6'd8) begin
                  state_q <= ST_COMPARE;
               end else begin
                  bit_cnt_q <= bit_cnt_q - 6'd1;
               end
            end
            ST_COMPARE: begin
               crc_ok_q <= (crc == frame[7:1]);
               end_ok_q <= frame[0];
               done_q   <= 1'b1;
               state_q  <= ST_DONE;
            end
            ST_DONE: begin
               if (start_wr) begin
                  done_q    <= 1'b0;
                  crc_ok_q  <= 1'b0;
                  end_ok_q  <= 1'b0;
                  bit_cnt_q <= 6'(FRAME_BITS - 1);
                  state_q   <= ST_SHIFT;
               end
`ifdef CRC7_CHECK_CLR_ON_READ_EN
               else if (rd_en && (addr == ADDR_STATUS)) begin
                  done_q   <= 1'b0;
                  crc_ok_q <= 1'b0;
                  end_ok_q <= 1'b0;
               end
`endif
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Status word assembly
   always_comb begin
      status              = 16'h0000;
      status[STAT_DONE]   = done_q;
      status[STAT_CRC_OK] = crc_ok_q;
      status[STAT_END_OK] = end_ok_q;
      status[STAT_BUSY]   = busy;
   end

   // Read mux; sources are pre-edge register values, so a same-cycle write
   // is not visible to the read
   always_comb begin
      d_out_d = 16'h0000;
      if (rd_en) begin
         case (addr)
            ADDR_FRAME_HI:  d_out_d = frame_hi_q;
            ADDR_FRAME_MID: d_out_d = frame_mid_q;
            ADDR_FRAME_LO:  d_out_d = frame_lo_q;
            ADDR_STATUS:    d_out_d = status;
            ADDR_CRC:       d_out_d = {9'h000, crc};
            default:        d_out_d = 16'h0000;
         endcase
      end
   end

   // Registered read data, zero when no read is strobed
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         d_out_q <= 16'h0000;
      end else begin
         d_out_q <= d_out_d;
      end
   end

   assign d_out = d_out_q;

endmodule : peripheral_crc_7_check

// File: tb/tb_peripheral_crc_7_check.sv
// Directed bench for peripheral_crc_7_check. Inputs change on the falling
// edge; each bus task spans exactly one rising edge and samples d_out on the
// following falling edge. Honors CRC7_CHECK_CLR_ON_READ_EN like the design.
module tb_peripheral_crc_7_check;

   logic        clk;
   logic        rst;
   logic [15:0] d_in;
   logic        cs;
   logic [3:0]  addr;
   logic        rd;
   logic        wr;
   logic [15:0] d_out;

   int n_vec;
   int n_err;

   peripheral_crc_7_check dut (
      .clk   (clk),
      .rst   (rst),
      .d_in  (d_in),
      .cs    (cs),
      .addr  (addr),
      .rd    (rd),
      .wr    (wr),
      .d_out (d_out)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
      cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; d_in = d;
      @(negedge clk);
      cs = 1'b0; wr = 1'b0; addr = 4'h0; d_in = 16'h0000;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
      cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
      @(negedge clk);
      d = d_out;
      cs = 1'b0; rd = 1'b0; addr = 4'h0;
   endtask

   task automatic bus_rw(input logic [3:0] a, input logic [15:0] wd, output logic [15:0] d);
      cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = a; d_in = wd;
      @(negedge clk);
      d = d_out;
      cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 4'h0; d_in = 16'h0000;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_frame(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
      bus_write(4'h0, w0);
      bus_write(4'h2, w1);
      bus_write(4'h4, w2);
   endtask

   // Start at edge S, then read status at S+41 (still COMPARE, busy) and at S+42
   task automatic run_check(input string tag, input logic [15:0] exp_status, input logic [15:0] exp_crc);
      logic [15:0] r;
      bus_write(4'h6, 16'h0001);
      idle(40);
      bus_read(4'h8, r);
      check({tag, "_pre_done"}, r, 16'h0008);
      bus_read(4'h8, r);
      check({tag, "_status"}, r, exp_status);
      bus_read(4'hA, r);
      check({tag, "_crc"}, r, exp_crc);
   endtask

   initial begin
      logic [15:0] r;
      n_vec = 0;
      n_err = 0;
      rst = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 4'h0; d_in = 16'h0000;

      // Reset state
      #1;
      check("reset_dout", d_out, 16'h0000);
      idle(2);
      rst = 1'b1;
      bus_read(4'h8, r);
      check("reset_status", r, 16'h0000);
      bus_read(4'h0, r);
      check("reset_word0", r, 16'h0000);

      // Frame word write/readback and d_out returns to 0 without a read
      load_frame(16'h4000, 16'h0000, 16'h0095);
      bus_read(4'h4, r);
      check("readback_word2", r, 16'h0095);
      idle(1);
      check("dout_idle_zero", d_out, 16'h0000);

      // CMD0, correct CRC
      bus_write(4'h6, 16'h0001);
      idle(40);
      bus_read(4'h8, r);
      check("cmd0_pre_done", r, 16'h0008);
      bus_read(4'h8, r);
      check("cmd0_status", r, 16'h0007);
      bus_read(4'h8, r);
`ifdef CRC7_CHECK_CLR_ON_READ_EN
      check("cmd0_status_reread", r, 16'h0000);
`else
      check("cmd0_status_reread", r, 16'h0007);
`endif
      bus_read(4'hA, r);
      check("cmd0_crc", r, 16'h004A);

      // CMD8, restarted from DONE
      load_frame(16'h4800, 16'h0001, 16'hAA87);
      run_check("cmd8", 16'h0007, 16'h0043);

      // CMD0 with corrupted CRC field, then with end bit cleared
      load_frame(16'h4000, 16'h0000, 16'h0097);
      run_check("cmd0_badcrc", 16'h0005, 16'h004A);
      bus_write(4'h4, 16'h0094);
      run_check("cmd0_badend", 16'h0003, 16'h004A);

      // Writes while busy are ignored
      bus_write(4'h4, 16'h0095);
      bus_write(4'h6, 16'h0001);        // edge S
      idle(19);
      bus_write(4'h0, 16'h1234);        // edge S+20
      bus_write(4'h6, 16'h0001);        // edge S+21
      bus_read(4'h8, r);                // edge S+22
      check("busy_during_shift", r, 16'h0008);
      idle(18);
      bus_read(4'h8, r);                // edge S+41
      check("busy_pre_done", r, 16'h0008);
      bus_read(4'h8, r);                // edge S+42
      check("busy_ignored_status", r, 16'h0007);
      bus_read(4'hA, r);
      check("busy_ignored_crc", r, 16'h004A);
      bus_read(4'h0, r);
      check("busy_word0_stable", r, 16'h4000);

      // Same-cycle read and write returns the pre-write value
      bus_rw(4'h0, 16'h5555, r);
      check("rw_prewrite", r, 16'h4000);
      bus_read(4'h0, r);
      check("rw_postwrite", r, 16'h5555);

      // Unmapped and write-only addresses read 0; status ignores writes
      bus_read(4'hC, r);
      check("unmapped_read", r, 16'h0000);
      bus_read(4'h6, r);
      check("ctrl_read", r, 16'h0000);
      bus_write(4'h8, 16'hFFFF);
      bus_read(4'h1, r);
      check("odd_addr_read", r, 16'h0000);

      // Reset in the middle of SHIFT
      bus_write(4'h0, 16'h4000);
      bus_write(4'h6, 16'h0001);        // edge S
      idle(9);
      #2 rst = 1'b0;
      #1;
      check("async_reset_dout", d_out, 16'h0000);
      idle(2);
      rst = 1'b1;
      bus_read(4'h8, r);
      check("midreset_status", r, 16'h0000);
      bus_read(4'h0, r);
      check("midreset_word0", r, 16'h0000);
      idle(50);
      bus_read(4'h8, r);
      check("midreset_no_done", r, 16'h0000);
      load_frame(16'h4000, 16'h0000, 16'h0095);
      run_check("after_reset", 16'h0007, 16'h004A);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_peripheral_crc_7_check
